// File: rtl/timer_alarm_sched.sv
// Alarm scheduler: keeps CH_NUM absolute targets, scans for the earliest pending one and
// pulses its fire bit when the timer count reaches it. Optional sticky status/IRQ: TIMER_ALARM_SCHED_IRQ_EN.
module timer_alarm_sched #(
   parameter int CH_NUM    = 4,
   parameter int CNT_WIDTH = 32,
   parameter int CH_WIDTH  = $clog2(CH_NUM)
) (
   input  logic                 clk_i,
   input  logic                 rst_n_i,
   input  logic [CNT_WIDTH-1:0] cnt_i,
   input  logic                 cnt_en_i,
   input  logic                 arm_valid_i,
   output logic                 arm_ready_o,
   input  logic [CH_WIDTH-1:0]  arm_ch_i,
   input  logic [CNT_WIDTH-1:0] arm_val_i,
   input  logic                 cancel_i,
   input  logic [CH_WIDTH-1:0]  cancel_ch_i,
   output logic [CH_NUM-1:0]    fire_o,
   output logic [CH_NUM-1:0]    pend_o,
   output logic                 next_vld_o,
   output logic [CH_WIDTH-1:0]  next_ch_o,
   output logic [CNT_WIDTH-1:0] next_val_o,
`ifdef TIMER_ALARM_SCHED_IRQ_EN
   output logic                 irq_o,
   output logic [CH_NUM-1:0]    stat_o,
   input  logic [CH_NUM-1:0]    stat_clr_i,
`endif
   output logic                 busy_o
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_WAIT = 2'd2
   } state_e;

   localparam logic [CH_WIDTH-1:0] LAST_CH  = CH_WIDTH'(CH_NUM - 1);
   localparam logic [CH_WIDTH-1:0] ONE_CH   = CH_WIDTH'(1);
   localparam logic [CH_WIDTH:0]   CH_LIMIT = (CH_WIDTH + 1)'(CH_NUM);

   // A target is overdue when it equals the scan base or lies in the past half of the ring.
   function automatic logic overdue(input logic [CNT_WIDTH-1:0] delta);
      return (delta == {CNT_WIDTH{1'b0}}) || delta[CNT_WIDTH-1];
   endfunction

   // Count has reached or passed the target (modulo); catches deadlines crossed during a scan.
   function automatic logic reached(input logic [CNT_WIDTH-1:0] cnt,
                                    input logic [CNT_WIDTH-1:0] tgt);
      logic [CNT_WIDTH-1:0] diff;
      diff = cnt - tgt;
      return ~diff[CNT_WIDTH-1];
   endfunction

   state_e               state_q, state_d;
   logic [CH_WIDTH-1:0]  idx_q, idx_d;
   logic [CNT_WIDTH-1:0] base_q, base_d;
   logic                 best_vld_q, best_vld_d;
   logic [CH_WIDTH-1:0]  best_ch_q, best_ch_d;
   logic [CNT_WIDTH-1:0] best_delta_q, best_delta_d;
   logic                 restart_q, restart_d;
   logic [CNT_WIDTH-1:0] target_q [CH_NUM];
   logic [CNT_WIDTH-1:0] target_d [CH_NUM];
   logic [CH_NUM-1:0]    pend_q, pend_d;
   logic [CH_NUM-1:0]    fire_q, fire_d;
   logic                 next_vld_q, next_vld_d;
   logic [CH_WIDTH-1:0]  next_ch_q, next_ch_d;
   logic [CNT_WIDTH-1:0] next_val_q, next_val_d;
   logic                 busy_q, busy_d;
   logic                 ready_q, ready_d;

   logic                 start_scan;
   logic                 restart_hit;
   logic                 cand_vld;
   logic [CH_WIDTH-1:0]  cand_ch;
   logic [CNT_WIDTH-1:0] cand_delta;
   logic [CNT_WIDTH-1:0] visit_delta;
   logic                 arm_acc;
   logic                 cancel_ok;
   logic                 cancel_next;
   logic                 cancel_cur;

   // Next-state: scheduler FSM, channel table updates and fire generation
   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      base_d       = base_q;
      best_vld_d   = best_vld_q;
      best_ch_d    = best_ch_q;
      best_delta_d = best_delta_q;
      restart_d    = restart_q;
      target_d     = target_q;
      pend_d       = pend_q;
      fire_d       = {CH_NUM{1'b0}};
      next_vld_d   = next_vld_q;
      next_ch_d    = next_ch_q;
      next_val_d   = next_val_q;
      start_scan   = 1'b0;
      restart_hit  = restart_q;
      cand_vld     = best_vld_q;
      cand_ch      = best_ch_q;
      cand_delta   = best_delta_q;
      visit_delta  = target_q[idx_q] - base_q;
      arm_acc      = arm_valid_i && (state_q != ST_SCAN) && ({1'b0, arm_ch_i} < CH_LIMIT);
      cancel_ok    = cancel_i && ({1'b0, cancel_ch_i} < CH_LIMIT);
      cancel_next  = cancel_ok && (cancel_ch_i == next_ch_q);
      cancel_cur   = cancel_ok && (cancel_ch_i == idx_q);

      case (state_q)
         ST_IDLE: begin
            if (arm_acc) begin
               start_scan = 1'b1;
            end else begin
               start_scan = 1'b0;
            end
         end
         ST_WAIT: begin
            // A cancel landing on the matching cycle suppresses the fire
            if (cnt_en_i && reached(cnt_i, next_val_q) && !cancel_next) begin
               fire_d[next_ch_q] = 1'b1;
               pend_d[next_ch_q] = 1'b0;
               start_scan        = 1'b1;
            end else if (cancel_next || arm_acc) begin
               start_scan = 1'b1;
            end else begin
               start_scan = 1'b0;
            end
         end
         ST_SCAN: begin
            if (pend_q[idx_q] && !cancel_cur) begin
               if (overdue(visit_delta)) begin
                  fire_d[idx_q] = 1'b1;
                  pend_d[idx_q] = 1'b0;
               end else if (!best_vld_q || (visit_delta < best_delta_q)) begin
                  cand_vld   = 1'b1;
                  cand_ch    = idx_q;
                  cand_delta = visit_delta;
               end else begin
                  cand_vld = best_vld_q;
               end
            end else begin
               cand_vld = best_vld_q;
            end
            if (cancel_ok && (cancel_ch_i < idx_q)) begin
               restart_hit = 1'b1;
            end else begin
               restart_hit = restart_q;
            end
            best_vld_d   = cand_vld;
            best_ch_d    = cand_ch;
            best_delta_d = cand_delta;
            restart_d    = restart_hit;
            if (idx_q == LAST_CH) begin
               if (restart_hit) begin
                  start_scan = 1'b1;
               end else if (cand_vld) begin
                  next_vld_d = 1'b1;
                  next_ch_d  = cand_ch;
                  next_val_d = target_q[cand_ch];
                  state_d    = ST_WAIT;
               end else begin
                  next_vld_d = 1'b0;
                  state_d    = ST_IDLE;
               end
            end else begin
               idx_d = idx_q + ONE_CH;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (start_scan) begin
         state_d    = ST_SCAN;
         idx_d      = {CH_WIDTH{1'b0}};
         base_d     = cnt_i;
         best_vld_d = 1'b0;
         restart_d  = 1'b0;
         next_vld_d = 1'b0;
      end else begin
         idx_d = idx_d;
      end

      // Cancel first so that a simultaneous arm of the same channel wins
      if (cancel_ok) begin
         pend_d[cancel_ch_i] = 1'b0;
      end else begin
         pend_d = pend_d;
      end
      if (arm_acc) begin
         target_d[arm_ch_i] = arm_val_i;
         pend_d[arm_ch_i]   = 1'b1;
      end else begin
         pend_d = pend_d;
      end

      busy_d  = (state_d == ST_SCAN);
      ready_d = (state_d != ST_SCAN);
   end

   // State and channel table registers
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q      <= ST_IDLE;
         idx_q        <= {CH_WIDTH{1'b0}};
         base_q       <= {CNT_WIDTH{1'b0}};
         best_vld_q   <= 1'b0;
         best_ch_q    <= {CH_WIDTH{1'b0}};
         best_delta_q <= {CNT_WIDTH{1'b0}};
         restart_q    <= 1'b0;
         for (int i = 0; i < CH_NUM; i++) begin
            target_q[i] <= {CNT_WIDTH{1'b0}};
         end
         pend_q       <= {CH_NUM{1'b0}};
         fire_q       <= {CH_NUM{1'b0}};
         next_vld_q   <= 1'b0;
         next_ch_q    <= {CH_WIDTH{1'b0}};
         next_val_q   <= {CNT_WIDTH{1'b0}};
         busy_q       <= 1'b0;
         ready_q      <= 1'b1;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         base_q       <= base_d;
         best_vld_q   <= best_vld_d;
         best_ch_q    <= best_ch_d;
         best_delta_q <= best_delta_d;
         restart_q    <= restart_d;
         target_q     <= target_d;
         pend_q       <= pend_d;
         fire_q       <= fire_d;
         next_vld_q   <= next_vld_d;
         next_ch_q    <= next_ch_d;
         next_val_q   <= next_val_d;
         busy_q       <= busy_d;
         ready_q      <= ready_d;
      end
   end

   assign arm_ready_o = ready_q;
   assign fire_o      = fire_q;
   assign pend_o      = pend_q;
   assign next_vld_o  = next_vld_q;
   assign next_ch_o   = next_ch_q;
   assign next_val_o  = next_val_q;
   assign busy_o      = busy_q;

`ifdef TIMER_ALARM_SCHED_IRQ_EN
   logic [CH_NUM-1:0] stat_q, stat_d;
   logic              irq_q, irq_d;

   // Sticky status: a fire in the same cycle as a write-1-clear keeps the bit set
   always_comb begin
      stat_d = (stat_q & ~stat_clr_i) | fire_q;
      irq_d  = |stat_d;
   end

   // Status and interrupt registers
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         stat_q <= {CH_NUM{1'b0}};
         irq_q  <= 1'b0;
      end else begin
         stat_q <= stat_d;
         irq_q  <= irq_d;
      end
   end

   assign stat_o = stat_q;
   assign irq_o  = irq_q;
`endif

endmodule

// File: tb/tb_timer_alarm_sched.sv
// Scoreboard bench for timer_alarm_sched: directed arm/cancel sequences against a
// bench-driven count; expected fire pulses are queued and checked by a separate monitor.
`timescale 1ns/1ps
module tb_timer_alarm_sched;
   localparam int CH_NUM    = 4;
   localparam int CNT_WIDTH = 32;
   localparam int CH_WIDTH  = 2;

   typedef struct packed {
      logic [CH_NUM-1:0]    mask;
      logic [CNT_WIDTH-1:0] cnt;
   } fire_exp_t;

   logic                 clk_i = 1'b0;
   logic                 rst_n_i;
   logic [CNT_WIDTH-1:0] cnt_i;
   logic                 cnt_en_i;
   logic                 arm_valid_i;
   logic                 arm_ready_o;
   logic [CH_WIDTH-1:0]  arm_ch_i;
   logic [CNT_WIDTH-1:0] arm_val_i;
   logic                 cancel_i;
   logic [CH_WIDTH-1:0]  cancel_ch_i;
   logic [CH_NUM-1:0]    fire_o;
   logic [CH_NUM-1:0]    pend_o;
   logic                 next_vld_o;
   logic [CH_WIDTH-1:0]  next_ch_o;
   logic [CNT_WIDTH-1:0] next_val_o;
   logic                 busy_o;
`ifdef TIMER_ALARM_SCHED_IRQ_EN
   logic                 irq_o;
   logic [CH_NUM-1:0]    stat_o;
   logic [CH_NUM-1:0]    stat_clr_i;
`endif

   fire_exp_t exp_q[$];
   int        checks = 0;
   int        errors = 0;
   bit        run    = 1'b0;

   timer_alarm_sched #(.CH_NUM(CH_NUM), .CNT_WIDTH(CNT_WIDTH)) dut (
      .clk_i       (clk_i),
      .rst_n_i     (rst_n_i),
      .cnt_i       (cnt_i),
      .cnt_en_i    (cnt_en_i),
      .arm_valid_i (arm_valid_i),
      .arm_ready_o (arm_ready_o),
      .arm_ch_i    (arm_ch_i),
      .arm_val_i   (arm_val_i),
      .cancel_i    (cancel_i),
      .cancel_ch_i (cancel_ch_i),
      .fire_o      (fire_o),
      .pend_o      (pend_o),
      .next_vld_o  (next_vld_o),
      .next_ch_o   (next_ch_o),
      .next_val_o  (next_val_o),
`ifdef TIMER_ALARM_SCHED_IRQ_EN
      .irq_o       (irq_o),
      .stat_o      (stat_o),
      .stat_clr_i  (stat_clr_i),
`endif
      .busy_o      (busy_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Fire monitor: every non-zero fire_o cycle must match the next queued expectation
   always @(negedge clk_i) begin
      fire_exp_t e;
      if (fire_o !== 4'b0000) begin
         if (exp_q.size() == 0) begin
            chk("fire_unexpected", 32'(fire_o), 32'd0);
         end else begin
            e = exp_q.pop_front();
            chk("fire_mask", 32'(fire_o), 32'(e.mask));
            chk("fire_cnt", cnt_i, e.cnt);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
      if (run) cnt_i = cnt_i + 32'd1;
   endtask

   task automatic arm(input logic [CH_WIDTH-1:0] ch, input logic [CNT_WIDTH-1:0] val);
      int n = 0;
      arm_valid_i = 1'b1;
      arm_ch_i    = ch;
      arm_val_i   = val;
      while (arm_ready_o !== 1'b1 && n < 64) begin
         tick();
         n++;
      end
      chk("arm_ready_wait", 32'(arm_ready_o), 32'd1);
      tick();
      arm_valid_i = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy_o !== 1'b0 && n < 64) begin
         tick();
         n++;
      end
      chk("busy_timeout", 32'(busy_o), 32'd0);
   endtask

   task automatic run_until(input logic [CNT_WIDTH-1:0] c);
      int n = 0;
      while (cnt_i != c && n < 4096) begin
         tick();
         n++;
      end
      if (n >= 4096) begin
         checks++;
         errors++;
         $display("FAIL run_until: count 0x%0h never reached 0x%0h", cnt_i, c);
      end
   endtask

   initial begin
      cnt_i       = 32'd0;
      cnt_en_i    = 1'b1;
      arm_valid_i = 1'b0;
      arm_ch_i    = 2'd0;
      arm_val_i   = 32'd0;
      cancel_i    = 1'b0;
      cancel_ch_i = 2'd0;
`ifdef TIMER_ALARM_SCHED_IRQ_EN
      stat_clr_i  = 4'b0000;
`endif
      rst_n_i     = 1'b1;
      #1 rst_n_i  = 1'b0;
      tick();
      tick();
      chk("rst_pend", 32'(pend_o), 32'd0);
      chk("rst_fire", 32'(fire_o), 32'd0);
      chk("rst_next_vld", 32'(next_vld_o), 32'd0);
      chk("rst_next_ch", 32'(next_ch_o), 32'd0);
      chk("rst_next_val", next_val_o, 32'd0);
      chk("rst_busy", 32'(busy_o), 32'd0);
      chk("rst_ready", 32'(arm_ready_o), 32'd1);
`ifdef TIMER_ALARM_SCHED_IRQ_EN
      chk("rst_stat", 32'(stat_o), 32'd0);
      chk("rst_irq", 32'(irq_o), 32'd0);
`endif
      rst_n_i = 1'b1;
      tick();

      // Single alarm: ch2 at 100, scan takes exactly four cycles
      cnt_i = 32'd10;
      run   = 1'b1;
      arm(2'd2, 32'd100);
      chk("t1_busy_entry", 32'(busy_o), 32'd1);
      chk("t1_ready_scan", 32'(arm_ready_o), 32'd0);
      tick(); tick(); tick();
      chk("t1_busy_3", 32'(busy_o), 32'd1);
      tick();
      chk("t1_busy_4", 32'(busy_o), 32'd0);
      chk("t1_next_vld", 32'(next_vld_o), 32'd1);
      chk("t1_next_ch", 32'(next_ch_o), 32'd2);
      chk("t1_next_val", next_val_o, 32'd100);
      chk("t1_pend", 32'(pend_o), 32'b0100);
      exp_q.push_back('{mask: 4'b0100, cnt: 32'd101});
      run_until(32'd110);
      chk("t1_pend_after", 32'(pend_o), 32'd0);
      chk("t1_next_vld_after", 32'(next_vld_o), 32'd0);
      chk("t1_idle", 32'(busy_o), 32'd0);

      // Three alarms with a tie: lower index wins, ch3 fires during the rescan
      run = 1'b0;
      arm(2'd0, 32'd500);
      arm(2'd1, 32'd300);
      arm(2'd3, 32'd300);
      wait_idle();
      chk("t2_next_ch", 32'(next_ch_o), 32'd1);
      chk("t2_next_val", next_val_o, 32'd300);
      chk("t2_pend", 32'(pend_o), 32'b1011);
      exp_q.push_back('{mask: 4'b0010, cnt: 32'd301});
      exp_q.push_back('{mask: 4'b1000, cnt: 32'd305});
      exp_q.push_back('{mask: 4'b0001, cnt: 32'd501});
      run = 1'b1;
      run_until(32'd510);
      chk("t2_pend_after", 32'(pend_o), 32'd0);

      // Wrap-around ordering
      run   = 1'b0;
      cnt_i = 32'hFFFF_FFF0;
      arm(2'd1, 32'h0000_0010);
      arm(2'd0, 32'hFFFF_FFF8);
      wait_idle();
      chk("t3_next_ch", 32'(next_ch_o), 32'd0);
      chk("t3_next_val", next_val_o, 32'hFFFF_FFF8);
      exp_q.push_back('{mask: 4'b0001, cnt: 32'hFFFF_FFF9});
      exp_q.push_back('{mask: 4'b0010, cnt: 32'h0000_0011});
      run = 1'b1;
      run_until(32'h0000_0020);
      chk("t3_pend_after", 32'(pend_o), 32'd0);

      // Overdue target fires during the scan
      run   = 1'b0;
      cnt_i = 32'd1000;
      exp_q.push_back('{mask: 4'b1000, cnt: 32'd1000});
      arm(2'd3, 32'd900);
      wait_idle();
      chk("t4_next_vld", 32'(next_vld_o), 32'd0);
      chk("t4_pend", 32'(pend_o), 32'd0);
      tick(); tick();

      // Cancel of the next channel, then arm+cancel on the same channel
      cnt_i = 32'd3000;
      arm(2'd1, 32'd3200);
      arm(2'd2, 32'd3300);
      wait_idle();
      chk("t5_next_ch_a", 32'(next_ch_o), 32'd1);
      chk("t5_next_val_a", next_val_o, 32'd3200);
      cancel_i    = 1'b1;
      cancel_ch_i = 2'd1;
      tick();
      cancel_i    = 1'b0;
      chk("t5_cancel_vld", 32'(next_vld_o), 32'd0);
      chk("t5_cancel_busy", 32'(busy_o), 32'd1);
      chk("t5_cancel_pend", 32'(pend_o), 32'b0100);
      wait_idle();
      chk("t5_next_ch_b", 32'(next_ch_o), 32'd2);
      chk("t5_next_val_b", next_val_o, 32'd3300);
      chk("t5_next_vld_b", 32'(next_vld_o), 32'd1);
      arm_valid_i = 1'b1;
      arm_ch_i    = 2'd0;
      arm_val_i   = 32'd3250;
      cancel_i    = 1'b1;
      cancel_ch_i = 2'd0;
      tick();
      arm_valid_i = 1'b0;
      cancel_i    = 1'b0;
      chk("t5_arm_cancel_pend", 32'(pend_o), 32'b0101);
      wait_idle();
      chk("t5_next_ch_c", 32'(next_ch_o), 32'd0);
      chk("t5_next_val_c", next_val_o, 32'd3250);
      exp_q.push_back('{mask: 4'b0001, cnt: 32'd3251});
      exp_q.push_back('{mask: 4'b0100, cnt: 32'd3301});
      run = 1'b1;
      run_until(32'd3310);

      // Count disabled across the deadline: no fire, then cancel it
      run   = 1'b0;
      cnt_i = 32'd4000;
      arm(2'd3, 32'd4005);
      wait_idle();
      cnt_en_i = 1'b0;
      run      = 1'b1;
      run_until(32'd4010);
      chk("t6_pend_hold", 32'(pend_o), 32'b1000);
      chk("t6_next_vld_hold", 32'(next_vld_o), 32'd1);
      cancel_i    = 1'b1;
      cancel_ch_i = 2'd3;
      tick();
      cancel_i    = 1'b0;
      wait_idle();
      chk("t6_pend_cancel", 32'(pend_o), 32'd0);
      chk("t6_next_vld_cancel", 32'(next_vld_o), 32'd0);
      cnt_en_i = 1'b1;

      // Reset during a scan that would fire an overdue channel
      run   = 1'b0;
      cnt_i = 32'd5000;
      arm(2'd0, 32'd4000);
      rst_n_i = 1'b0;
      tick();
      tick();
      chk("t7_pend", 32'(pend_o), 32'd0);
      chk("t7_busy", 32'(busy_o), 32'd0);
      chk("t7_ready", 32'(arm_ready_o), 32'd1);
      rst_n_i = 1'b1;
      repeat (6) tick();

`ifdef TIMER_ALARM_SCHED_IRQ_EN
      cnt_i = 32'd6000;
      arm(2'd0, 32'd6002);
      wait_idle();
      exp_q.push_back('{mask: 4'b0001, cnt: 32'd6003});
      run = 1'b1;
      run_until(32'd6003);
      tick();
      chk("t8_stat_set", 32'(stat_o), 32'b0001);
      chk("t8_irq_set", 32'(irq_o), 32'd1);
      run = 1'b0;
      arm(2'd0, 32'd6007);
      wait_idle();
      exp_q.push_back('{mask: 4'b0001, cnt: 32'd6008});
      run = 1'b1;
      run_until(32'd6008);
      stat_clr_i = 4'b0001;
      tick();
      stat_clr_i = 4'b0000;
      chk("t8_stat_set_wins", 32'(stat_o), 32'b0001);
      chk("t8_irq_set_wins", 32'(irq_o), 32'd1);
      stat_clr_i = 4'b0001;
      tick();
      stat_clr_i = 4'b0000;
      chk("t8_stat_clr", 32'(stat_o), 32'd0);
      chk("t8_irq_clr", 32'(irq_o), 32'd0);
      run = 1'b0;
`endif

      repeat (4) tick();
      chk("exp_queue_empty", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
